pin_run_counter: RTL and testbench
==================================

Name: pin_run_counter

Overview:
- Stimulus source for the on-chip logic analyser probe group.
- Synchronises and debounces the user pin pin_84, then detects its rising edges.
- Each rising edge steps a three-state run control (IDLE -> RUN -> HOLD -> IDLE).
- The block drives the free-running counter bus and the status bits that the analyser samples on sys_clk.

Parameters:
CNT_W, 16, width of counter output (>=2)
DEBOUNCE_CYCLES, 1000, consecutive stable synchronised cycles required before pin_db changes (>=1)
DB_W, 16, width of internal debounce counter; must satisfy DEBOUNCE_CYCLES <= 2**DB_W

Ports:
sys_clk  in  1  system clock; all logic on rising edge
sys_rst  in  1  asynchronous, active-high reset
pin_84  in  1  raw asynchronous pin, bouncy
pin_db  out  1  debounced pin level
pin_rise  out  1  one-cycle pulse on pin_db 0->1
state  out  2  run state: 00 IDLE, 01 RUN, 10 HOLD (11 unused)
counter  out  CNT_W  run counter value
wrap  out  1  one-cycle pulse when counter wraps all-ones -> 0

Behaviour:
- Reset: the block uses one clock (sys_clk). Reset sys_rst is asynchronous and active-high.
  - Assertion forces: sync FFs=0, db_cnt=0, pin_db=0, pin_rise=0, state=IDLE, counter=0, wrap=0.
  - Release takes effect on the next sys_clk edge.
  - Reset mid-RUN or mid-debounce discards all progress.
- Synchroniser: two FFs, pin_84 -> s1 -> s2. s2 is the only consumer of the pin.
- Debounce, per cycle:
  - If s2 == pin_db: db_cnt <= 0.
  - Else if db_cnt == DEBOUNCE_CYCLES-1: pin_db <= s2, db_cnt <= 0.
  - Else: db_cnt <= db_cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES cycles at s2 never changes pin_db.
  - Latency from a clean pin_84 step to the pin_db change: 2+DEBOUNCE_CYCLES sys_clk edges (+1 for sampling alignment).
- pin_rise: registered; high for exactly the one cycle in which pin_db first reads 1 after 0. It is asserted on the same edge that sets pin_db.
- FSM, advanced by pin_rise as seen on the cycle after it is asserted (registered input):
  - IDLE: counter held at 0; pin_rise -> RUN.
  - RUN: counter <= counter+1 every cycle; pin_rise -> HOLD.
  - HOLD: counter frozen; pin_rise -> IDLE, clearing counter to 0 on that edge.
  - Illegal state 11: recovers to IDLE with counter=0 on the next edge.
- Counter arithmetic: unsigned, modulo 2**CNT_W.
  - In RUN with counter all-ones, the next edge gives counter=0 and wrap=1 for one cycle.
  - wrap is 0 in all other cycles.
- Simultaneous events: if in RUN with counter all-ones and pin_rise is taken on the same edge:
  - HOLD wins: counter stays all-ones, no wrap pulse, state=HOLD.
- First cycle of RUN: counter increments from 0 on the edge after entering RUN. The sequence is 0 (entry), 1, 2, ...
- Outputs are all registered; no combinational path from pin_84 to any output.

Test Plan:
- Reset: DEBOUNCE_CYCLES=4, pin_84=1 held, sys_rst pulsed mid-stream -> all outputs 0 during reset; pin_db rises 6-7 edges after release.
- Glitch rejection: DEBOUNCE_CYCLES=4, pin_84 high for 3 cycles then low -> pin_db stays 0, pin_rise never asserted, state stays IDLE.
- Run/hold/clear:
  - Three clean presses, each 10 cycles high / 10 low.
  - Expect state 00->01->10->00.
  - counter climbs 1,2,3... in RUN, freezes in HOLD, becomes 0 on the third press.
- Wrap: CNT_W=4, enter RUN and run 20 cycles -> counter goes 15 then 0, wrap high exactly one cycle at the 0, then counter continues 1,2,...
- Simultaneous: CNT_W=4, time the press so pin_rise is taken with counter=15 in RUN -> state=HOLD, counter=15, wrap stays 0.
- Async reset in RUN: assert sys_rst between edges with counter=7 -> counter=0 and state=IDLE immediately, before the next sys_clk edge.

Source files
------------

// File: rtl/pin_run_counter.sv
// Debounced pin-press run controller: synchronise and debounce pin_84, detect rising edges,
// and step an IDLE -> RUN -> HOLD -> IDLE counter that feeds the logic analyser probe group.
module pin_run_counter #(
    parameter int CNT_W           = 16,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int DB_W            = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             pin_84,
    output logic             pin_db,
    output logic             pin_rise,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] counter,
    output logic             wrap
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10,
        ST_BAD  = 2'b11
    } run_state_t;

    localparam logic [DB_W-1:0]  DB_LAST      = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ALL_ONES = '1;

    logic             s1_q;
    logic             s2_q;
    logic [DB_W-1:0]  db_cnt_q;
    logic [DB_W-1:0]  db_cnt_d;
    logic             pin_db_q;
    logic             pin_db_d;
    logic             pin_rise_q;
    logic             pin_rise_d;
    run_state_t       state_q;
    run_state_t       state_d;
    logic [CNT_W-1:0] counter_q;
    logic [CNT_W-1:0] counter_d;
    logic             wrap_q;
    logic             wrap_d;

    // Two-flop synchroniser; s2_q is the only consumer of the raw pin.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= pin_84;
            s2_q <= s1_q;
        end
    end

    // db_cnt counts consecutive cycles in which s2 disagrees with the debounced level.
    always_comb begin
        db_cnt_d   = db_cnt_q;
        pin_db_d   = pin_db_q;
        pin_rise_d = 1'b0;
        if (s2_q == pin_db_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            pin_db_d   = s2_q;
            pin_rise_d = s2_q;
            db_cnt_d   = '0;
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            db_cnt_q   <= '0;
            pin_db_q   <= 1'b0;
            pin_rise_q <= 1'b0;
        end else begin
            db_cnt_q   <= db_cnt_d;
            pin_db_q   <= pin_db_d;
            pin_rise_q <= pin_rise_d;
        end
    end

    // A press taken in RUN freezes the counter, so it beats a simultaneous wrap.
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        wrap_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                counter_d = '0;
                if (pin_rise_q) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (pin_rise_q) begin
                    state_d = ST_HOLD;
                end else begin
                    counter_d = counter_q + CNT_W'(1);
                    wrap_d    = (counter_q == CNT_ALL_ONES);
                end
            end
            ST_HOLD: begin
                if (pin_rise_q) begin
                    state_d   = ST_IDLE;
                    counter_d = '0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                counter_d = '0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= ST_IDLE;
            counter_q <= '0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            wrap_q    <= wrap_d;
        end
    end

    assign pin_db   = pin_db_q;
    assign pin_rise = pin_rise_q;
    assign state    = state_q;
    assign counter  = counter_q;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_pin_run_counter.sv
// Bench for pin_run_counter: segment table, hand-written corner sequences and random pin
// activity, all compared every cycle against a window-based behavioural model.
module tb_pin_run_counter;

    localparam int CNT_W = 4;
    localparam int DB    = 4;
    localparam int DB_W  = 4;

    logic             sys_clk = 1'b0;
    logic             sys_rst = 1'b1;
    logic             pin_84  = 1'b0;
    logic             pin_db;
    logic             pin_rise;
    logic [1:0]       state;
    logic [CNT_W-1:0] counter;
    logic             wrap;

    pin_run_counter #(
        .CNT_W          (CNT_W),
        .DEBOUNCE_CYCLES(DB),
        .DB_W           (DB_W)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .pin_84  (pin_84),
        .pin_db  (pin_db),
        .pin_rise(pin_rise),
        .state   (state),
        .counter (counter),
        .wrap    (wrap)
    );

    always #5 sys_clk = ~sys_clk;

    int vectors = 0;
    int misses  = 0;

    // Behavioural model: pin samples reach the debouncer two edges late; the debounced
    // level flips once the last DB samples it saw all disagree with it.
    bit       pipe[$];
    bit       win[$];
    bit       m_db;
    bit       m_rise;
    bit       m_wrap;
    bit [1:0] m_st;
    int       m_cnt;

    task automatic model_reset();
        pipe   = '{1'b0, 1'b0};
        win.delete();
        m_db   = 1'b0;
        m_rise = 1'b0;
        m_wrap = 1'b0;
        m_st   = 2'd0;
        m_cnt  = 0;
    endtask

    task automatic model_advance();
        bit seen;
        bit take;
        bit all_diff;
        bit flipped;
        if (sys_rst) begin
            model_reset();
            return;
        end
        take = m_rise;
        seen = pipe.pop_front();
        pipe.push_back(pin_84);
        win.push_back(seen);
        if (win.size() > DB) void'(win.pop_front());
        flipped = 1'b0;
        if (win.size() == DB) begin
            all_diff = 1'b1;
            foreach (win[i]) if (win[i] == m_db) all_diff = 1'b0;
            if (all_diff) begin
                m_db    = !m_db;
                flipped = 1'b1;
            end
        end
        m_rise = flipped && m_db;
        m_wrap = 1'b0;
        case (m_st)
            2'd0: begin
                m_cnt = 0;
                if (take) m_st = 2'd1;
            end
            2'd1: begin
                if (take) m_st = 2'd2;
                else begin
                    m_cnt = m_cnt + 1;
                    if (m_cnt == (1 << CNT_W)) begin
                        m_cnt  = 0;
                        m_wrap = 1'b1;
                    end
                end
            end
            2'd2: begin
                if (take) begin
                    m_st  = 2'd0;
                    m_cnt = 0;
                end
            end
            default: begin
                m_st  = 2'd0;
                m_cnt = 0;
            end
        endcase
    endtask

    task automatic check_vec(string name);
        logic [CNT_W-1:0] exp_cnt;
        exp_cnt = m_cnt[CNT_W-1:0];
        vectors++;
        if (pin_db !== m_db || pin_rise !== m_rise || state !== m_st ||
            counter !== exp_cnt || wrap !== m_wrap) begin
            misses++;
            $display("FAIL %s t=%0t: got db=%0b rise=%0b st=%0d cnt=%0d wrap=%0b, expected db=%0b rise=%0b st=%0d cnt=%0d wrap=%0b",
                     name, $time, pin_db, pin_rise, state, counter, wrap,
                     m_db, m_rise, m_st, exp_cnt, m_wrap);
        end
    endtask

    task automatic chk(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            misses++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock: advance the model with the inputs present before the edge, compare at negedge.
    task automatic tick(string name);
        model_advance();
        @(posedge sys_clk);
        @(negedge sys_clk);
        check_vec(name);
    endtask

    task automatic hold_pin(bit level, int n, string name);
        pin_84 = level;
        for (int i = 0; i < n; i++) tick(name);
    endtask

    // Reset asserted between edges must clear the outputs before the next edge.
    task automatic async_reset(string name);
        #2;
        sys_rst = 1'b1;
        #1;
        model_reset();
        check_vec({name, "_async"});
        @(negedge sys_clk);
        tick({name, "_inrst"});
        sys_rst = 1'b0;
    endtask

    typedef struct {
        bit       pin;
        int       cycles;
        bit [1:0] exp_state;
        bit       exp_db;
        int       exp_cnt;
    } seg_t;

    seg_t tbl[8];

    initial begin
        int n;
        // Glitch of DB-1 cycles, then three clean presses (RUN, HOLD, IDLE).
        tbl[0] = '{1'b1,  3, 2'd0, 1'b0, 0};
        tbl[1] = '{1'b0, 12, 2'd0, 1'b0, 0};
        tbl[2] = '{1'b1, 10, 2'd1, 1'b1, 3};
        tbl[3] = '{1'b0, 10, 2'd1, 1'b0, 13};
        tbl[4] = '{1'b1, 10, 2'd2, 1'b1, 3};
        tbl[5] = '{1'b0, 10, 2'd2, 1'b0, 3};
        tbl[6] = '{1'b1, 10, 2'd0, 1'b1, 0};
        tbl[7] = '{1'b0, 10, 2'd0, 1'b0, 0};

        model_reset();
        repeat (2) @(negedge sys_clk);
        check_vec("reset_state");
        tick("reset_hold");
        sys_rst = 1'b0;
        hold_pin(1'b0, 4, "post_reset");

        foreach (tbl[i]) begin
            hold_pin(tbl[i].pin, tbl[i].cycles, "table");
            chk($sformatf("seg%0d_state", i), int'(state), int'(tbl[i].exp_state));
            chk($sformatf("seg%0d_db", i), int'(pin_db), int'(tbl[i].exp_db));
            chk($sformatf("seg%0d_cnt", i), int'(counter), tbl[i].exp_cnt);
            $display("segment %0d: pin=%0b x%0d -> state=%0d db=%0b cnt=%0d",
                     i, tbl[i].pin, tbl[i].cycles, state, pin_db, counter);
        end

        // Simultaneous press and wrap: pin_rise taken while counter is all-ones in RUN.
        hold_pin(1'b1, 10, "sim_enter");
        chk("sim_in_run", int'(state), 1);
        pin_84 = 1'b0;
        n = 0;
        do begin
            tick("sim_wait");
            n++;
        end while ((n < 8 || counter != CNT_W'(9)) && n < 40);
        chk("sim_wait_bound", int'(counter), 9);
        hold_pin(1'b1, 7, "sim_press");
        chk("sim_state", int'(state), 2);
        chk("sim_cnt", int'(counter), 15);
        chk("sim_wrap", int'(wrap), 0);
        $display("simultaneous: state=%0d cnt=%0d wrap=%0b", state, counter, wrap);

        // Back to IDLE, then into RUN and reset asynchronously at counter 7.
        hold_pin(1'b0, 10, "ar_rel");
        hold_pin(1'b1, 10, "ar_idle");
        hold_pin(1'b0, 10, "ar_rel2");
        hold_pin(1'b1, 10, "ar_run");
        n = 0;
        while (counter != CNT_W'(7) && n < 40) begin
            tick("ar_wait");
            n++;
        end
        chk("ar_cnt7", int'(counter), 7);
        async_reset("ar");
        chk("ar_cnt_cleared", int'(counter), 0);
        chk("ar_state_cleared", int'(state), 0);
        n = 0;
        while (pin_db !== 1'b1 && n < 20) begin
            tick("ar_release");
            n++;
        end
        chk("ar_db_latency", n, 6);
        $display("async reset in RUN: pin_db rose %0d edges after release", n);

        // Random pin activity with occasional asynchronous resets.
        for (int s = 0; s < 300; s++) begin
            if ($urandom_range(0, 99) < 3) begin
                async_reset("rnd");
            end else begin
                hold_pin(1'($urandom_range(0, 1)), int'($urandom_range(1, 12)), "random");
            end
        end
        $display("random: done, state=%0d cnt=%0d", state, counter);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
